multicycle_main_controller: RTL and testbench
=============================================

Name: multicycle_main_controller

Overview:
Multicycle sequencer for the MIPS datapath. Steps each instruction through fetch, decode, execute, memory and writeback over several cycles on a shared ALU and unified memory. It replaces the single-cycle decode path when the core runs in multicycle mode. It issues all datapath enables and muxes, the ALU operation and the memory request handshake, and flags unsupported instructions.

Parameters:
Op_Code_Width, 6, opcode field width
Funct_Width, 6, funct field width
ALU_Control_Width, 3, ALU operation select width

Ports:
CLK  in  1  rising-edge clock
RST  in  1  asynchronous active-low reset
Op_Code  in  6  Instr[31:26], taken from the instruction register
Funct  in  6  Instr[5:0], taken from the instruction register
Zero  in  1  ALU zero flag
Mem_Ready  in  1  memory access completes this cycle
Mem_Req  out  1  memory access requested
Mem_write  out  1  access is a write (only valid with Mem_Req)
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
IR_write  out  1  load the instruction register
Reg_write  out  1  register file write enable
Reg_Dest  out  1  write register select: 0 = rt, 1 = rd
Mem_to_Reg  out  1  write data select: 0 = ALUOut, 1 = data register
ALU_Src_A  out  1  ALU A select: 0 = PC, 1 = register A
ALU_Src_B  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
ALU_Control  out  3  010 add, 100 sub, 110 slt, 101 mul
PC_Src  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
PC_en  out  1  PC load enable
Illegal_Instr  out  1  one-cycle pulse on an unsupported opcode or funct

Behaviour:
- Single clock. RST is asynchronous, active-low. On RST low the state is forced to FETCH immediately.
- Defaults: every output is 0 in every state unless listed below. ALU_Control defaults to 010. While RST is low all outputs are 0, except ALU_Control = 010.
- Deassertion of RST is synchronized externally. The first active edge after release begins a fetch.
- Output timing: state-driven (Moore). The exceptions are IR_write, PC_en and the completion of memory accesses, which are additionally qualified by Mem_Ready or Zero as stated below.
- Memory handshake:
  - Mem_Req stays high in FETCH, MEMREAD and MEMWRITE until Mem_Ready is sampled high. The state holds while Mem_Ready is 0; wait states are unbounded.
  - Mem_write and IorD stay stable for the whole request.
- FETCH:
  - Outputs: Mem_Req=1, IorD=0, ALU_Src_A=0, ALU_Src_B=01, add, PC_Src=00.
  - IR_write=PC_en=Mem_Ready.
  - Advances to DECODE on Mem_Ready.
- DECODE:
  - Outputs: ALU_Src_A=0, ALU_Src_B=11, add. The branch target is latched into ALUOut by the datapath.
  - Next state: lw or sw (100011 / 101011) -> MEMADR; R-type (000000) -> EXECUTE; addi (001000) -> ADDIEX; beq (000100) -> BRANCH; j (000010) -> JUMP.
  - Any other opcode: Illegal_Instr=1 this cycle, then FETCH. The PC has already advanced by 4.
- MEMADR: ALU_Src_A=1, ALU_Src_B=10, add. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: Mem_Req=1, IorD=1. Advances to MEMWB on Mem_Ready.
- MEMWB: Reg_write=1, Reg_Dest=0, Mem_to_Reg=1. Next state FETCH.
- MEMWRITE: Mem_Req=1, Mem_write=1, IorD=1. The write commits in the Mem_Ready cycle, then FETCH.
- EXECUTE:
  - ALU_Src_A=1, ALU_Src_B=00. ALU_Control comes from Funct: 100000 -> 010, 100010 -> 100, 101010 -> 110, 011100 -> 101.
  - Any other funct: ALU_Control=010, Illegal_Instr=1, next FETCH. There is no writeback.
  - Otherwise next ALUWB.
- ALUWB: Reg_write=1, Reg_Dest=1, Mem_to_Reg=0. Next FETCH.
- ADDIEX: ALU_Src_A=1, ALU_Src_B=10, add. Next ADDIWB.
- ADDIWB: Reg_write=1, Reg_Dest=0, Mem_to_Reg=0. Next FETCH.
- BRANCH: ALU_Src_A=1, ALU_Src_B=00, sub, PC_Src=01, PC_en=Zero. Next FETCH.
- JUMP: PC_Src=10, PC_en=1. Next FETCH.
- Latency with zero-wait memory (Mem_Ready always high), in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each memory wait cycle adds 1.
- Reset asserted mid-instruction abandons it with no further register or memory writes. A pending Mem_Req drops asynchronously.
- Mem_Ready outside the three request states is ignored.
- The state encoding is internal. An unreachable encoding recovers to FETCH on the next edge.

Decomposition:
- Shared package holds the opcode and funct constants (lw, sw, R-type, addi, beq, j; add, sub, slt, mul), the ALU_Control codes, the ALU_Src_B and PC_Src encodings, and the state enumeration.
- One sub-module, alu_decoder: combinational mapping of (ALU operation class, Funct) to ALU_Control plus a funct-illegal flag. The class is add, sub or funct. This block instantiates it.

Test Plan:
- RST low mid-MEMWRITE with Mem_Req=1 -> Mem_Req and Mem_write go to 0 with no clock edge; after release the first cycle is FETCH.
- lw, Mem_Ready always 1 -> 5 cycles (FETCH, DECODE, MEMADR, MEMREAD, MEMWB); Reg_write=1 with Mem_to_Reg=1 only in cycle 5.
- sw, Mem_Ready low for 3 cycles in MEMWRITE -> Mem_Req=Mem_write=1, IorD=1 held for 4 cycles, then FETCH.
- beq with Zero=1, then beq with Zero=0 -> BRANCH cycle shows PC_Src=01, ALU_Control=100, and PC_en=1 then 0 respectively.
- R-type with Funct=011100, then with Funct=000111 -> first gives ALU_Control=101 in EXECUTE then ALUWB (Reg_Dest=1); second pulses Illegal_Instr and returns to FETCH with no Reg_write.
- Opcode 111111 -> Illegal_Instr=1 in the DECODE cycle only; the next cycle is FETCH with Mem_Req=1.

Source files
------------

// File: rtl/multicycle_main_controller_pkg.sv
// Shared constants and types for the multicycle MIPS main controller:
// instruction field codes, datapath mux encodings, ALU codes and FSM states.
package multicycle_main_controller_pkg;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011100;

    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b100;
    localparam logic [2:0] ALUC_SLT = 3'b110;
    localparam logic [2:0] ALUC_MUL = 3'b101;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'd0,
        ALU_OP_SUB   = 2'd1,
        ALU_OP_FUNCT = 2'd2
    } alu_op_e;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECUTE  = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_ADDIEX   = 4'd8,
        ST_ADDIWB   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dest;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       illegal_instr;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{alu_control: ALUC_ADD, default: '0};

endpackage

// File: rtl/multicycle_main_controller_if.sv
// Controller <-> datapath/memory bundle: instruction fields and status in,
// enables, mux selects, ALU operation and memory request out.
interface multicycle_main_controller_if #(
    parameter int Op_Code_Width     = 6,
    parameter int Funct_Width       = 6,
    parameter int ALU_Control_Width = 3
);
    logic [Op_Code_Width-1:0]     Op_Code;
    logic [Funct_Width-1:0]       Funct;
    logic                         Zero;
    logic                         Mem_Ready;
    logic                         Mem_Req;
    logic                         Mem_write;
    logic                         IorD;
    logic                         IR_write;
    logic                         Reg_write;
    logic                         Reg_Dest;
    logic                         Mem_to_Reg;
    logic                         ALU_Src_A;
    logic [1:0]                   ALU_Src_B;
    logic [ALU_Control_Width-1:0] ALU_Control;
    logic [1:0]                   PC_Src;
    logic                         PC_en;
    logic                         Illegal_Instr;

    modport master (
        input  Op_Code, Funct, Zero, Mem_Ready,
        output Mem_Req, Mem_write, IorD, IR_write, Reg_write, Reg_Dest,
               Mem_to_Reg, ALU_Src_A, ALU_Src_B, ALU_Control, PC_Src,
               PC_en, Illegal_Instr
    );

    modport slave (
        output Op_Code, Funct, Zero, Mem_Ready,
        input  Mem_Req, Mem_write, IorD, IR_write, Reg_write, Reg_Dest,
               Mem_to_Reg, ALU_Src_A, ALU_Src_B, ALU_Control, PC_Src,
               PC_en, Illegal_Instr
    );
endinterface

// File: rtl/multicycle_main_controller_alu_decoder.sv
// Maps the ALU operation class (add / sub / funct) and the funct field to
// the ALU control code, flagging funct values the ALU does not implement.
module multicycle_main_controller_alu_decoder
    import multicycle_main_controller_pkg::*;
#(
    parameter int Funct_Width       = 6,
    parameter int ALU_Control_Width = 3
) (
    input  alu_op_e                      alu_op,
    input  logic [Funct_Width-1:0]       funct,
    output logic [ALU_Control_Width-1:0] alu_control,
    output logic                         funct_illegal
);

    always_comb begin
        alu_control   = ALU_Control_Width'(ALUC_ADD);
        funct_illegal = 1'b0;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_Control_Width'(ALUC_ADD);
            ALU_OP_SUB: alu_control = ALU_Control_Width'(ALUC_SUB);
            ALU_OP_FUNCT: begin
                case (funct)
                    Funct_Width'(FN_ADD): alu_control = ALU_Control_Width'(ALUC_ADD);
                    Funct_Width'(FN_SUB): alu_control = ALU_Control_Width'(ALUC_SUB);
                    Funct_Width'(FN_SLT): alu_control = ALU_Control_Width'(ALUC_SLT);
                    Funct_Width'(FN_MUL): alu_control = ALU_Control_Width'(ALUC_MUL);
                    default:              funct_illegal = 1'b1;
                endcase
            end
            default: alu_control = ALU_Control_Width'(ALUC_ADD);
        endcase
    end

endmodule

// File: rtl/multicycle_main_controller.sv
// Multicycle MIPS sequencer: Moore FSM stepping fetch/decode/execute/memory/
// writeback, with memory completion, IR/PC loads and branches qualified live.
module multicycle_main_controller
    import multicycle_main_controller_pkg::*;
#(
    parameter int Op_Code_Width     = 6,
    parameter int Funct_Width       = 6,
    parameter int ALU_Control_Width = 3
) (
    input logic                          CLK,
    input logic                          RST,
    multicycle_main_controller_if.master bus
);

    state_e                       state_q;
    state_e                       state_d;
    alu_op_e                      alu_op;
    logic [ALU_Control_Width-1:0] dec_alu_control;
    logic                         dec_funct_illegal;
    ctrl_t                        ctrl;
    ctrl_t                        ctrl_o;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        alu_op = ALU_OP_ADD;
        case (state_q)
            ST_EXECUTE: alu_op = ALU_OP_FUNCT;
            ST_BRANCH:  alu_op = ALU_OP_SUB;
            default:    alu_op = ALU_OP_ADD;
        endcase
    end

    multicycle_main_controller_alu_decoder #(
        .Funct_Width       (Funct_Width),
        .ALU_Control_Width (ALU_Control_Width)
    ) u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (bus.Funct),
        .alu_control   (dec_alu_control),
        .funct_illegal (dec_funct_illegal)
    );

    always_comb begin
        ctrl             = CTRL_IDLE;
        ctrl.alu_control = 3'(dec_alu_control);
        state_d          = state_q;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = bus.Mem_Ready;
                ctrl.pc_en     = bus.Mem_Ready;
                if (bus.Mem_Ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                // ALU computes PC+4 + (imm<<2) so the branch target is ready in ALUOut
                ctrl.alu_src_b = SRCB_IMM_SH2;
                case (bus.Op_Code)
                    Op_Code_Width'(OP_LW),
                    Op_Code_Width'(OP_SW):    state_d = ST_MEMADR;
                    Op_Code_Width'(OP_RTYPE): state_d = ST_EXECUTE;
                    Op_Code_Width'(OP_ADDI):  state_d = ST_ADDIEX;
                    Op_Code_Width'(OP_BEQ):   state_d = ST_BRANCH;
                    Op_Code_Width'(OP_J):     state_d = ST_JUMP;
                    default: begin
                        ctrl.illegal_instr = 1'b1;
                        state_d            = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d = (bus.Op_Code == Op_Code_Width'(OP_SW)) ? ST_MEMWRITE : ST_MEMREAD;
            end
            ST_MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                if (bus.Mem_Ready) state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = ST_FETCH;
            end
            ST_MEMWRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                if (bus.Mem_Ready) state_d = ST_FETCH;
            end
            ST_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                if (dec_funct_illegal) begin
                    ctrl.illegal_instr = 1'b1;
                    state_d            = ST_FETCH;
                end else begin
                    state_d = ST_ALUWB;
                end
            end
            ST_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dest  = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.pc_en     = bus.Zero;
                state_d        = ST_FETCH;
            end
            ST_JUMP: begin
                ctrl.pc_src = PCSRC_JUMP;
                ctrl.pc_en  = 1'b1;
                state_d     = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Gate with RST so an abandoned request drops without waiting for a clock edge
    always_comb begin
        ctrl_o = RST ? ctrl : CTRL_IDLE;
    end

    assign bus.Mem_Req       = ctrl_o.mem_req;
    assign bus.Mem_write     = ctrl_o.mem_write;
    assign bus.IorD          = ctrl_o.iord;
    assign bus.IR_write      = ctrl_o.ir_write;
    assign bus.Reg_write     = ctrl_o.reg_write;
    assign bus.Reg_Dest      = ctrl_o.reg_dest;
    assign bus.Mem_to_Reg    = ctrl_o.mem_to_reg;
    assign bus.ALU_Src_A     = ctrl_o.alu_src_a;
    assign bus.ALU_Src_B     = ctrl_o.alu_src_b;
    assign bus.ALU_Control   = ALU_Control_Width'(ctrl_o.alu_control);
    assign bus.PC_Src        = ctrl_o.pc_src;
    assign bus.PC_en         = ctrl_o.pc_en;
    assign bus.Illegal_Instr = ctrl_o.illegal_instr;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Directed bench for the multicycle main controller: walks each instruction
// class cycle by cycle and compares the full control word every cycle.
module tb_multicycle_main_controller;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    multicycle_main_controller_if #(
        .Op_Code_Width(6), .Funct_Width(6), .ALU_Control_Width(3)
    ) bus ();

    multicycle_main_controller #(
        .Op_Code_Width(6), .Funct_Width(6), .ALU_Control_Width(3)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {Mem_Req, Mem_write, IorD, IR_write, Reg_write, Reg_Dest, Mem_to_Reg,
    //  ALU_Src_A, ALU_Src_B[1:0], ALU_Control[2:0], PC_Src[1:0], PC_en, Illegal_Instr}
    function automatic logic [16:0] o(input logic mreq, input logic mw, input logic iord,
                                      input logic irw, input logic rw, input logic rd,
                                      input logic m2r, input logic asa, input logic [1:0] asb,
                                      input logic [2:0] aluc, input logic [1:0] pcs,
                                      input logic pcen, input logic ill);
        return {mreq, mw, iord, irw, rw, rd, m2r, asa, asb, aluc, pcs, pcen, ill};
    endfunction

    function automatic logic [16:0] observed();
        return {bus.Mem_Req, bus.Mem_write, bus.IorD, bus.IR_write, bus.Reg_write,
                bus.Reg_Dest, bus.Mem_to_Reg, bus.ALU_Src_A, bus.ALU_Src_B,
                bus.ALU_Control, bus.PC_Src, bus.PC_en, bus.Illegal_Instr};
    endfunction

    task automatic check(input string tag, input logic [16:0] exp);
        logic [16:0] got;
        got = observed();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic zr, input logic rdy, input logic [16:0] exp);
        @(negedge clk);
        bus.Op_Code   = op;
        bus.Funct     = fn;
        bus.Zero      = zr;
        bus.Mem_Ready = rdy;
        #1;
        check(tag, exp);
    endtask

    logic [16:0] e_reset, e_fetch, e_fetch_wait, e_decode, e_decode_ill, e_memadr;
    logic [16:0] e_memread, e_memwb, e_memwrite, e_exec_mul, e_exec_ill, e_aluwb;
    logic [16:0] e_addiwb, e_br_t, e_br_nt, e_jump;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, J = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    initial begin
        errors = 0;
        checks = 0;
        e_reset      = o(0,0,0,0,0,0,0,0,2'b00,3'b010,2'b00,0,0);
        e_fetch      = o(1,0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0);
        e_fetch_wait = o(1,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0);
        e_decode     = o(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0);
        e_decode_ill = o(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,1);
        e_memadr     = o(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
        e_memread    = o(1,0,1,0,0,0,0,0,2'b00,3'b010,2'b00,0,0);
        e_memwb      = o(0,0,0,0,1,0,1,0,2'b00,3'b010,2'b00,0,0);
        e_memwrite   = o(1,1,1,0,0,0,0,0,2'b00,3'b010,2'b00,0,0);
        e_exec_mul   = o(0,0,0,0,0,0,0,1,2'b00,3'b101,2'b00,0,0);
        e_exec_ill   = o(0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,1);
        e_aluwb      = o(0,0,0,0,1,1,0,0,2'b00,3'b010,2'b00,0,0);
        e_addiwb     = o(0,0,0,0,1,0,0,0,2'b00,3'b010,2'b00,0,0);
        e_br_t       = o(0,0,0,0,0,0,0,1,2'b00,3'b100,2'b01,1,0);
        e_br_nt      = o(0,0,0,0,0,0,0,1,2'b00,3'b100,2'b01,0,0);
        e_jump       = o(0,0,0,0,0,0,0,0,2'b00,3'b010,2'b10,1,0);

        rst_n         = 1'b0;
        bus.Op_Code   = LW;
        bus.Funct     = 6'b100000;
        bus.Zero      = 1'b0;
        bus.Mem_Ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", e_reset);

        // lw, zero-wait: 5 cycles
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("lw_fetch", e_fetch);
        step("lw_decode",  LW, 6'd0, 1'b0, 1'b1, e_decode);
        step("lw_memadr",  LW, 6'd0, 1'b0, 1'b1, e_memadr);
        step("lw_memread", LW, 6'd0, 1'b0, 1'b1, e_memread);
        step("lw_memwb",   LW, 6'd0, 1'b0, 1'b1, e_memwb);

        // sw with a fetch wait and three write wait states
        step("sw_fetch_wait", SW, 6'd0, 1'b0, 1'b0, e_fetch_wait);
        step("sw_fetch",      SW, 6'd0, 1'b0, 1'b1, e_fetch);
        step("sw_decode",     SW, 6'd0, 1'b0, 1'b1, e_decode);
        step("sw_memadr",     SW, 6'd0, 1'b0, 1'b1, e_memadr);
        step("sw_wait1",      SW, 6'd0, 1'b0, 1'b0, e_memwrite);
        step("sw_wait2",      SW, 6'd0, 1'b0, 1'b0, e_memwrite);
        step("sw_wait3",      SW, 6'd0, 1'b0, 1'b0, e_memwrite);
        step("sw_commit",     SW, 6'd0, 1'b0, 1'b1, e_memwrite);

        // beq taken, then not taken
        step("beq1_fetch",  BEQ, 6'd0, 1'b0, 1'b1, e_fetch);
        step("beq1_decode", BEQ, 6'd0, 1'b0, 1'b1, e_decode);
        step("beq1_branch", BEQ, 6'd0, 1'b1, 1'b1, e_br_t);
        step("beq0_fetch",  BEQ, 6'd0, 1'b1, 1'b1, e_fetch);
        step("beq0_decode", BEQ, 6'd0, 1'b1, 1'b1, e_decode);
        step("beq0_branch", BEQ, 6'd0, 1'b0, 1'b1, e_br_nt);

        // R-type mul, then R-type with unsupported funct
        step("mul_fetch",   RT, 6'b011100, 1'b0, 1'b1, e_fetch);
        step("mul_decode",  RT, 6'b011100, 1'b0, 1'b1, e_decode);
        step("mul_execute", RT, 6'b011100, 1'b0, 1'b1, e_exec_mul);
        step("mul_aluwb",   RT, 6'b011100, 1'b0, 1'b1, e_aluwb);
        step("badfn_fetch",   RT, 6'b000111, 1'b0, 1'b1, e_fetch);
        step("badfn_decode",  RT, 6'b000111, 1'b0, 1'b1, e_decode);
        step("badfn_execute", RT, 6'b000111, 1'b0, 1'b1, e_exec_ill);

        // addi; Mem_Ready low outside request states must not stall
        step("addi_fetch",  ADDI, 6'd0, 1'b0, 1'b1, e_fetch);
        step("addi_decode", ADDI, 6'd0, 1'b0, 1'b0, e_decode);
        step("addi_ex",     ADDI, 6'd0, 1'b0, 1'b0, e_memadr);
        step("addi_wb",     ADDI, 6'd0, 1'b0, 1'b0, e_addiwb);

        // j
        step("j_fetch",  J, 6'd0, 1'b0, 1'b1, e_fetch);
        step("j_decode", J, 6'd0, 1'b0, 1'b1, e_decode);
        step("j_jump",   J, 6'd0, 1'b0, 1'b1, e_jump);

        // unsupported opcode
        step("badop_fetch",  BAD, 6'd0, 1'b0, 1'b1, e_fetch);
        step("badop_decode", BAD, 6'd0, 1'b0, 1'b1, e_decode_ill);
        step("badop_next",   BAD, 6'd0, 1'b0, 1'b1, e_fetch);

        // reset asserted mid-MEMWRITE drops the request without a clock edge
        step("rstw_decode", SW, 6'd0, 1'b0, 1'b1, e_decode);
        step("rstw_memadr", SW, 6'd0, 1'b0, 1'b1, e_memadr);
        step("rstw_write",  SW, 6'd0, 1'b0, 1'b0, e_memwrite);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw_async_drop", e_reset);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.Op_Code   = J;
        bus.Mem_Ready = 1'b1;
        #1;
        check("rstw_first_fetch", e_fetch);
        step("rstw_decode2", J, 6'd0, 1'b0, 1'b1, e_decode);
        step("rstw_jump",    J, 6'd0, 1'b0, 1'b1, e_jump);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
